prepare_eng_log_wr_ctrl: RTL and testbench
==========================================

# prepare_eng_log_wr_ctrl

Parametrised log-write controller for the VR prepare engine. It sits between the realigner's data stream and the log header and log data memories. It owns the circular log tail pointer, performs the space check against the replica's truncation head, and writes data lines at generated addresses. It writes one header per accepted entry after that entry's data has landed. Entries without space are drained and counted.

## Interface
Parameters:
- `DATA_W`, 512: data line width in bits.
- `LOG_ADDR_W`, 10: log data memory address width; depth is 2^LOG_ADDR_W lines.
- `HDR_ADDR_W`, 8: header memory address width; one header slot per entry.
- `LEN_W`, 8: width of the per-request line count.
- `DROP_CNT_W`, 16: width of the drop counter.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
  - `clk`, in, 1: clock.
  - `rst`, in, 1: synchronous, active-high reset.
- Request side:
  - `start_req_ingest_val`, in, 1: new request.
  - `start_req_ingest_lines`, in, LEN_W: lines the request declares.
  - `start_req_ingest_rdy`, out, 1: controller accepts a request.
  - `log_write_done`, out, 1: controller idle.
- Realigner side:
  - `realign_log_ctrl_rd_val`, in, 1; `realign_log_ctrl_rd_data`, in, DATA_W; `realign_log_ctrl_rd_last`, in, 1.
  - `log_ctrl_realign_rd_rdy`, out, 1.
- Data memory write:
  - `prep_log_data_mem_wr_val`, out, 1; `prep_log_data_mem_wr_addr`, out, LOG_ADDR_W; `prep_log_data_mem_wr_data`, out, DATA_W.
  - `log_data_mem_prep_wr_rdy`, in, 1.
- Header memory write:
  - `prep_log_hdr_mem_wr_val`, out, 1; `prep_log_hdr_mem_wr_addr`, out, HDR_ADDR_W; `prep_log_hdr_mem_wr_data`, out, `log_hdr_struct` (start addr, line count, truncated flag).
  - `log_hdr_mem_prep_wr_rdy`, in, 1.
- Log pointers:
  - `log_head_ptr`, in, LOG_ADDR_W+1: truncation head, with wrap bit.
  - `log_tail_ptr`, out, LOG_ADDR_W+1: committed tail, with wrap bit.
- `drop_cnt`, out, DROP_CNT_W: number of dropped entries; saturates at all-ones.

## Operation
- States: IDLE, WRITE, DRAIN, HDR.
- IDLE:
  - `start_req_ingest_rdy`=1 and `log_write_done`=1.
  - free = 2^LOG_ADDR_W − (tail − head), computed mod 2^(LOG_ADDR_W+1).
  - On start handshake with 1 ≤ lines ≤ free: latch lines, clear beat count, go to WRITE.
  - Otherwise (lines=0 or lines > free): increment drop_cnt, go to DRAIN.
- WRITE:
  - Data memory val = realign val; realign rdy = memory rdy.
  - Data memory addr = tail[LOG_ADDR_W−1:0] + beat count, mod depth (wrap).
  - On each handshake, beat count increments.
  - If beat count reaches latched lines before `last`: remaining beats are consumed with rdy=1 and not written, and the truncated flag is set.
  - On the `last` beat (written or consumed), go to HDR.
- DRAIN: rdy=1, nothing written; on val & last go to IDLE.
- HDR:
  - Header val=1; addr = entry counter; data = {tail, beat count written, truncated}.
  - On handshake: tail += beats written, entry counter += 1 (wraps at 2^HDR_ADDR_W), go to IDLE.
- An early `last` (fewer beats than declared) commits only the beats actually written.

## Timing
- Reset values:
  - State IDLE; tail=0; entry counter=0; drop_cnt=0.
  - All val/rdy outputs 0 except `start_req_ingest_rdy` and `log_write_done`, which are 1.
- Handshakes: a transfer occurs only when val & rdy are both high. Data memory ports are a combinational pass-through with no buffering and zero added latency.
- Space decision uses `log_head_ptr` in the start cycle. A head update in that same cycle is seen; later head updates do not affect an in-flight entry.
- The tail is stable during WRITE and changes only at the HDR handshake. It is visible the cycle after.
- Minimum entry cost: 1 start cycle + N data cycles + 1 header cycle. Back-to-back starts are accepted one cycle after the HDR handshake.
- A `last` in the same beat as reaching the declared count is a normal completion with truncated=0.
- Reset mid-entry: return to IDLE. Uncommitted data is abandoned, and the tail does not advance.

## Structure
- Package `prepare_log_pkg`: `log_hdr_struct`, the state enum, and a free-space width localparam.
- Sub-module `log_space_calc`: combinational free-space and has-space computation from head, tail and lines.
- All state lives in the top module.

## Test plan
- DEPTH=16, head=0, tail=0, lines=4 → addrs 0..3 written; header {0,4,0} at slot 0; tail=4.
- tail=14, head=2 (free=4), lines=4 → addrs 14,15,0,1; tail wraps to 18 (binary 1_0010).
- head=0, tail=12 (free=4), lines=5 → no data writes; 5 beats drained; drop_cnt=1; no header; tail unchanged.
- lines=3, stream of 5 beats → 3 writes, 2 beats consumed; header len=3, truncated=1.
- lines=4, `last` on beat 2 → header len=2; tail advances by 2.
- Memory rdy toggled 1,0,0,1 during WRITE and header rdy held low 3 cycles → no lost or duplicated beats; the state stays in HDR until rdy; then reset mid-WRITE → IDLE, tail=0.

Source files
------------

// File: rtl/prepare_log_pkg.sv
// Shared types for the prepare-engine log writer.
//   log_hdr_struct : header memory payload {start addr, lines written, truncated}
//   state_e        : log write controller states
//   FREE_W_MAX     : width of free-space values and log pointers (addr width + wrap bit)
package prepare_log_pkg;

  localparam int unsigned LOG_ADDR_W_MAX = 10;
  localparam int unsigned FREE_W_MAX     = LOG_ADDR_W_MAX + 1;
  localparam int unsigned HDR_LEN_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HDR   = 2'd3
  } state_e;

  // Header fields are sized for the largest supported log; smaller logs zero-extend.
  typedef struct packed {
    logic [FREE_W_MAX-1:0] start_addr;
    logic [HDR_LEN_W-1:0]  line_cnt;
    logic                  truncated;
  } log_hdr_struct;

endpackage

// File: rtl/log_space_calc.sv
// Free-space check for the circular log.
//   head, tail  : pointers with wrap bit
//   lines       : requested line count
//   free_c      : lines available = depth - (tail - head)
//   has_space_c : lines is non-zero and fits in free space
module log_space_calc #(
  parameter int unsigned LOG_ADDR_W = 10,
  parameter int unsigned LEN_W      = 8
) (
  input  logic [LOG_ADDR_W:0]  head,
  input  logic [LOG_ADDR_W:0]  tail,
  input  logic [LEN_W-1:0]     lines,
  output logic [LOG_ADDR_W:0]  free_c,
  output logic                 has_space_c
);

  localparam int unsigned FREE_W = LOG_ADDR_W + 1;
  localparam int unsigned CMP_W  = (LEN_W > FREE_W) ? LEN_W : FREE_W;
  localparam logic [FREE_W-1:0] DEPTH = {1'b1, {LOG_ADDR_W{1'b0}}};

  // Occupancy wraps naturally in FREE_W bits thanks to the wrap bit.
  always_comb begin
    free_c      = DEPTH - (tail - head);
    has_space_c = (lines != '0) && (CMP_W'(lines) <= CMP_W'(free_c));
  end

endmodule

// File: rtl/prepare_eng_log_wr_ctrl.sv
// Log write controller: accepts a request, checks space against the truncation
// head, streams realigner lines into the log data memory at tail-relative
// addresses, then writes one header and commits the tail. Requests that do not
// fit are drained and counted.
//   start_req_ingest_*        : request handshake, log_write_done = idle
//   realign_log_ctrl_rd_*     : incoming data stream
//   prep_log_data_mem_wr_*    : data memory write (pass-through in WRITE)
//   prep_log_hdr_mem_wr_*     : header memory write
//   log_head_ptr/log_tail_ptr : circular log pointers with wrap bit
//   drop_cnt                  : saturating count of dropped entries
module prepare_eng_log_wr_ctrl
  import prepare_log_pkg::*;
#(
  parameter int unsigned DATA_W     = 512,
  parameter int unsigned LOG_ADDR_W = 10,
  parameter int unsigned HDR_ADDR_W = 8,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_req_ingest_val,
  input  logic [LEN_W-1:0]      start_req_ingest_lines,
  output logic                  start_req_ingest_rdy,
  output logic                  log_write_done,
  input  logic                  realign_log_ctrl_rd_val,
  input  logic [DATA_W-1:0]     realign_log_ctrl_rd_data,
  input  logic                  realign_log_ctrl_rd_last,
  output logic                  log_ctrl_realign_rd_rdy,
  output logic                  prep_log_data_mem_wr_val,
  output logic [LOG_ADDR_W-1:0] prep_log_data_mem_wr_addr,
  output logic [DATA_W-1:0]     prep_log_data_mem_wr_data,
  input  logic                  log_data_mem_prep_wr_rdy,
  output logic                  prep_log_hdr_mem_wr_val,
  output logic [HDR_ADDR_W-1:0] prep_log_hdr_mem_wr_addr,
  output log_hdr_struct         prep_log_hdr_mem_wr_data,
  input  logic                  log_hdr_mem_prep_wr_rdy,
  input  logic [LOG_ADDR_W:0]   log_head_ptr,
  output logic [LOG_ADDR_W:0]   log_tail_ptr,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int unsigned PTR_W = LOG_ADDR_W + 1;

  state_e                state;
  logic [HDR_ADDR_W-1:0] entry_cnt;
  logic [LEN_W-1:0]      lines_q;
  logic [LEN_W-1:0]      beat_cnt;
  logic                  trunc_q;

  logic [PTR_W-1:0]      free_c;
  logic                  has_space_c;
  logic                  room_c;
  logic                  rd_xfer_c;

  log_space_calc #(
    .LOG_ADDR_W (LOG_ADDR_W),
    .LEN_W      (LEN_W)
  ) u_space (
    .head        (log_head_ptr),
    .tail        (log_tail_ptr),
    .lines       (start_req_ingest_lines),
    .free_c      (free_c),
    .has_space_c (has_space_c)
  );

  // beat_cnt never exceeds lines_q, so inequality means there is room left.
  assign room_c    = (beat_cnt != lines_q);
  assign rd_xfer_c = realign_log_ctrl_rd_val & log_ctrl_realign_rd_rdy;

  // Output decode from the state register; data memory is a pass-through.
  always_comb begin
    start_req_ingest_rdy      = 1'b0;
    log_write_done            = 1'b0;
    log_ctrl_realign_rd_rdy   = 1'b0;
    prep_log_data_mem_wr_val  = 1'b0;
    prep_log_hdr_mem_wr_val   = 1'b0;
    prep_log_data_mem_wr_addr = log_tail_ptr[LOG_ADDR_W-1:0] + LOG_ADDR_W'(beat_cnt);
    prep_log_data_mem_wr_data = realign_log_ctrl_rd_data;
    prep_log_hdr_mem_wr_addr  = entry_cnt;
    prep_log_hdr_mem_wr_data            = '0;
    prep_log_hdr_mem_wr_data.start_addr = FREE_W_MAX'(log_tail_ptr);
    prep_log_hdr_mem_wr_data.line_cnt   = HDR_LEN_W'(beat_cnt);
    prep_log_hdr_mem_wr_data.truncated  = trunc_q;
    case (state)
      ST_IDLE: begin
        start_req_ingest_rdy = 1'b1;
        log_write_done       = 1'b1;
      end
      ST_WRITE: begin
        // Beats past the declared count are swallowed without a write.
        prep_log_data_mem_wr_val = realign_log_ctrl_rd_val & room_c;
        log_ctrl_realign_rd_rdy  = room_c ? log_data_mem_prep_wr_rdy : 1'b1;
      end
      ST_DRAIN: log_ctrl_realign_rd_rdy = 1'b1;
      ST_HDR:   prep_log_hdr_mem_wr_val = 1'b1;
      default: ;
    endcase
  end

  // Controller state, tail pointer, entry and drop counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      log_tail_ptr <= '0;
      entry_cnt    <= '0;
      drop_cnt     <= '0;
      lines_q      <= '0;
      beat_cnt     <= '0;
      trunc_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_req_ingest_val) begin
            if (has_space_c) begin
              lines_q  <= start_req_ingest_lines;
              beat_cnt <= '0;
              trunc_q  <= 1'b0;
              state    <= ST_WRITE;
            end else begin
              if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
              state <= ST_DRAIN;
            end
          end
        end
        ST_WRITE: begin
          if (rd_xfer_c) begin
            if (room_c) beat_cnt <= beat_cnt + LEN_W'(1);
            else        trunc_q  <= 1'b1;
            if (realign_log_ctrl_rd_last) state <= ST_HDR;
          end
        end
        ST_DRAIN: begin
          if (realign_log_ctrl_rd_val && realign_log_ctrl_rd_last) state <= ST_IDLE;
        end
        ST_HDR: begin
          if (log_hdr_mem_prep_wr_rdy) begin
            log_tail_ptr <= log_tail_ptr + PTR_W'(beat_cnt);
            entry_cnt    <= entry_cnt + HDR_ADDR_W'(1);
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prepare_eng_log_wr_ctrl.sv
// Testbench for prepare_eng_log_wr_ctrl with a 16-line log. An entry-level
// reference model predicts data writes, header contents, tail and drop count.
module tb_prepare_eng_log_wr_ctrl;
  import prepare_log_pkg::*;

  localparam int unsigned DATA_W     = 512;
  localparam int unsigned LOG_ADDR_W = 4;
  localparam int unsigned HDR_ADDR_W = 8;
  localparam int unsigned LEN_W      = 8;
  localparam int unsigned DROP_CNT_W = 16;
  localparam int DEPTH = 16;
  localparam int PMOD  = 32;

  logic                  clk;
  logic                  rst;
  logic                  start_val;
  logic [LEN_W-1:0]      start_lines;
  logic                  start_rdy;
  logic                  write_done;
  logic                  rd_val;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_last;
  logic                  rd_rdy;
  logic                  mem_val;
  logic [LOG_ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_data;
  logic                  mem_rdy;
  logic                  hdr_val;
  logic [HDR_ADDR_W-1:0] hdr_addr;
  log_hdr_struct         hdr_data;
  logic                  hdr_rdy;
  logic [LOG_ADDR_W:0]   head_ptr;
  logic [LOG_ADDR_W:0]   tail_ptr;
  logic [DROP_CNT_W-1:0] drop_cnt;

  int unsigned vectors;
  int unsigned errors;

  // Reference model state
  int m_tail;
  int m_entry;
  int m_drop;

  logic [LOG_ADDR_W-1:0] mon_addr[$];
  logic [DATA_W-1:0]     mon_data[$];
  logic [HDR_ADDR_W-1:0] mon_slot[$];
  log_hdr_struct         mon_hdr[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  prepare_eng_log_wr_ctrl #(
    .DATA_W(DATA_W), .LOG_ADDR_W(LOG_ADDR_W), .HDR_ADDR_W(HDR_ADDR_W),
    .LEN_W(LEN_W), .DROP_CNT_W(DROP_CNT_W)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .start_req_ingest_val      (start_val),
    .start_req_ingest_lines    (start_lines),
    .start_req_ingest_rdy      (start_rdy),
    .log_write_done            (write_done),
    .realign_log_ctrl_rd_val   (rd_val),
    .realign_log_ctrl_rd_data  (rd_data),
    .realign_log_ctrl_rd_last  (rd_last),
    .log_ctrl_realign_rd_rdy   (rd_rdy),
    .prep_log_data_mem_wr_val  (mem_val),
    .prep_log_data_mem_wr_addr (mem_addr),
    .prep_log_data_mem_wr_data (mem_data),
    .log_data_mem_prep_wr_rdy  (mem_rdy),
    .prep_log_hdr_mem_wr_val   (hdr_val),
    .prep_log_hdr_mem_wr_addr  (hdr_addr),
    .prep_log_hdr_mem_wr_data  (hdr_data),
    .log_hdr_mem_prep_wr_rdy   (hdr_rdy),
    .log_head_ptr              (head_ptr),
    .log_tail_ptr              (tail_ptr),
    .drop_cnt                  (drop_cnt)
  );

  // Record every completed memory write
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_val && mem_rdy) begin
        mon_addr.push_back(mem_addr);
        mon_data.push_back(mem_data);
      end
      if (hdr_val && hdr_rdy) begin
        mon_slot.push_back(hdr_addr);
        mon_hdr.push_back(hdr_data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [DATA_W-1:0] rand_line();
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic clear_mon();
    mon_addr.delete();
    mon_data.delete();
    mon_slot.delete();
    mon_hdr.delete();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    start_val = 1'b0; start_lines = '0;
    rd_val = 1'b0; rd_data = '0; rd_last = 1'b0;
    mem_rdy = 1'b0; hdr_rdy = 1'b0; head_ptr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_tail = 0; m_entry = 0; m_drop = 0;
    clear_mon();
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    vectors++; if (start_rdy !== 1'b1) begin errors++; $display("FAIL reset_start_rdy: got %b want 1", start_rdy); end
    vectors++; if (write_done !== 1'b1) begin errors++; $display("FAIL reset_done: got %b want 1", write_done); end
    vectors++; if (tail_ptr !== '0) begin errors++; $display("FAIL reset_tail: got %0d want 0", tail_ptr); end
    vectors++; if (drop_cnt !== '0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    vectors++;
    if (rd_rdy !== 1'b0 || mem_val !== 1'b0 || hdr_val !== 1'b0) begin
      errors++; $display("FAIL reset_vals: got rd_rdy=%b mem_val=%b hdr_val=%b want 0 0 0", rd_rdy, mem_val, hdr_val);
    end
    @(posedge clk); #1;
  endtask

  // One entry: request, data stream, header; mode 0 = always ready,
  // 1 = random val/rdy, 2 = memory rdy pattern 1,0,0,1.
  task automatic test_entry(input string name, input int head, input int lines,
                            input int nbeats, input int hdr_stall, input int mode);
    logic [DATA_W-1:0] beats[$];
    log_hdr_struct     exp_hdr;
    int h, occ, free, w, i, cyc, n;
    bit ok, done_seen;

    for (int k = 0; k < nbeats; k++) beats.push_back(rand_line());
    h    = ((head % PMOD) + PMOD) % PMOD;
    occ  = ((m_tail - h) % PMOD + PMOD) % PMOD;
    free = DEPTH - occ;
    ok   = (lines >= 1) && (lines <= free);
    w    = ok ? ((nbeats < lines) ? nbeats : lines) : 0;
    clear_mon();

    head_ptr    = 5'(h);
    start_val   = 1'b1;
    start_lines = 8'(lines);
    @(negedge clk);
    vectors++; if (start_rdy !== 1'b1) begin errors++; $display("FAIL %s start_rdy: got %b want 1", name, start_rdy); end
    @(posedge clk); #1;
    start_val = 1'b0;

    i = 0; cyc = 0;
    while (i < nbeats && cyc < 2000) begin
      rd_val  = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      rd_data = beats[i];
      rd_last = (i == nbeats - 1);
      case (mode)
        1:       mem_rdy = 1'($urandom_range(0, 1));
        2:       mem_rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: mem_rdy = 1'b1;
      endcase
      @(negedge clk);
      if (rd_val && rd_rdy) i++;
      @(posedge clk); #1;
      cyc++;
    end
    rd_val = 1'b0; rd_last = 1'b0; mem_rdy = 1'b0;
    vectors++; if (i < nbeats) begin errors++; $display("FAIL %s stream_timeout: got %0d beats want %0d", name, i, nbeats); end

    if (ok) begin
      for (int s = 0; s < hdr_stall; s++) begin
        @(negedge clk);
        vectors++;
        if (hdr_val !== 1'b1 || write_done !== 1'b0) begin
          errors++; $display("FAIL %s hdr_hold: got val=%b done=%b want 1 0", name, hdr_val, write_done);
        end
        @(posedge clk); #1;
      end
    end
    hdr_rdy = 1'b1;
    done_seen = 1'b0;
    for (int c = 0; c < 20 && !done_seen; c++) begin
      @(negedge clk);
      done_seen = write_done;
      @(posedge clk); #1;
    end
    hdr_rdy = 1'b0;
    vectors++; if (!done_seen) begin errors++; $display("FAIL %s done_timeout: got busy want idle", name); end

    vectors++;
    if (mon_addr.size() != w) begin
      errors++; $display("FAIL %s write_count: got %0d want %0d", name, mon_addr.size(), w);
    end
    n = (mon_addr.size() < w) ? mon_addr.size() : w;
    for (int k = 0; k < n; k++) begin
      vectors++;
      if (mon_addr[k] !== 4'((m_tail + k) % DEPTH) || mon_data[k] !== beats[k]) begin
        errors++; $display("FAIL %s write_%0d: got addr %0d want addr %0d (data match=%0b)",
                           name, k, mon_addr[k], (m_tail + k) % DEPTH, mon_data[k] === beats[k]);
      end
    end

    vectors++;
    if (mon_hdr.size() != (ok ? 1 : 0)) begin
      errors++; $display("FAIL %s hdr_count: got %0d want %0d", name, mon_hdr.size(), ok ? 1 : 0);
    end
    if (ok && mon_hdr.size() >= 1) begin
      exp_hdr.start_addr = 11'(m_tail);
      exp_hdr.line_cnt   = 8'(w);
      exp_hdr.truncated  = (nbeats > lines);
      vectors++;
      if (mon_hdr[0] !== exp_hdr || mon_slot[0] !== 8'(m_entry)) begin
        errors++; $display("FAIL %s hdr: got slot %0d {%0d,%0d,%0b} want slot %0d {%0d,%0d,%0b}", name,
                           mon_slot[0], mon_hdr[0].start_addr, mon_hdr[0].line_cnt, mon_hdr[0].truncated,
                           m_entry, exp_hdr.start_addr, exp_hdr.line_cnt, exp_hdr.truncated);
      end
    end

    if (ok) begin
      m_tail  = (m_tail + w) % PMOD;
      m_entry = (m_entry + 1) % 256;
    end else if (m_drop < 65535) begin
      m_drop++;
    end

    @(negedge clk);
    vectors++; if (tail_ptr !== 5'(m_tail)) begin errors++; $display("FAIL %s tail: got %0d want %0d", name, tail_ptr, m_tail); end
    vectors++; if (drop_cnt !== 16'(m_drop)) begin errors++; $display("FAIL %s drop_cnt: got %0d want %0d", name, drop_cnt, m_drop); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    test_entry("basic", 0, 4, 4, 0, 0);
  endtask

  task automatic test_wrap();
    test_entry("fill10", 0, 10, 10, 0, 1);
    test_entry("wrap", 2, 4, 4, 0, 0);
  endtask

  task automatic test_drop();
    apply_reset();
    test_entry("fill12", 0, 12, 12, 0, 0);
    test_entry("no_space", 0, 5, 5, 0, 0);
    test_entry("zero_lines", 0, 0, 2, 0, 1);
  endtask

  task automatic test_truncate();
    test_entry("truncate", 0, 3, 5, 0, 0);
  endtask

  task automatic test_early_last();
    test_entry("early_last", m_tail, 4, 2, 0, 0);
  endtask

  task automatic test_backpressure();
    test_entry("backpressure", m_tail, 6, 6, 3, 2);
  endtask

  task automatic test_reset_mid_write();
    clear_mon();
    head_ptr    = 5'(m_tail);
    start_val   = 1'b1;
    start_lines = 8'd4;
    @(posedge clk); #1;
    start_val = 1'b0;
    rd_val = 1'b1; rd_last = 1'b0; mem_rdy = 1'b1; rd_data = rand_line();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    rd_val = 1'b0; mem_rdy = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    m_tail = 0; m_entry = 0; m_drop = 0;
    @(negedge clk);
    vectors++; if (write_done !== 1'b1) begin errors++; $display("FAIL rst_mid done: got %b want 1", write_done); end
    vectors++; if (tail_ptr !== '0) begin errors++; $display("FAIL rst_mid tail: got %0d want 0", tail_ptr); end
    vectors++; if (mon_hdr.size() != 0) begin errors++; $display("FAIL rst_mid hdr_count: got %0d want 0", mon_hdr.size()); end
    @(posedge clk); #1;
    test_entry("after_reset", 0, 2, 2, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int e = 0; e < 25; e++) begin
      test_entry("random", m_tail - int'($urandom_range(0, 16)),
                 int'($urandom_range(0, 7)), int'($urandom_range(1, 9)),
                 int'($urandom_range(0, 2)), 1);
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_drop();
    test_truncate();
    test_early_last();
    test_backpressure();
    test_reset_mid_write();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
